// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Default constants shared by the button debouncer blocks, plus a small
// helper used to range-check parameters at elaboration time.
// Ports: none (package).
// ---------------------------------------------------------------------------
package debounce_pkg;

  // Default stability counter width and terminal value (about 0.65 ms at 100 MHz)
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_CNT_MAX     = 65535;

  // Default synchroniser depth for the raw asynchronous button inputs
  localparam int DEF_SYNC_STAGES = 2;

  // Default long-press counter width and threshold (0.1 s at 100 MHz)
  localparam int DEF_HOLD_W      = 24;
  localparam int DEF_HOLD_MAX    = 10_000_000;

  // True when value lies in 1 .. 2^width-1, i.e. it is a usable nonzero
  // terminal count for a counter of the given width.
  function automatic logic fitsWidth(input longint value, input int width);
    return (value >= 64'sd1) && (value <= ((longint'(1) << width) - 64'sd1));
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
// One fully independent button channel: input synchroniser, polarity
// normalisation, stability counter, debounced level, press/release pulses
// and an optional long-press detector.
// Ports:
//   i_clk      system clock, all state on the rising edge
//   i_rst      synchronous active-high reset
//   i_btn      raw asynchronous button level
//   o_level    debounced, normalised level (1 = pressed)
//   o_press    one-cycle pulse on o_level 0->1
//   o_release  one-cycle pulse on o_level 1->0
//   o_long     one-cycle pulse once per press after HOLD_MAX cycles held
// ---------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   CNT_W       = DEF_CNT_W,
  parameter int   CNT_MAX     = DEF_CNT_MAX,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INV         = 1'b0,
  parameter int   HOLD_W      = DEF_HOLD_W,
  parameter int   HOLD_MAX    = DEF_HOLD_MAX,
  parameter int   LONG_EN     = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  logic [SYNC_STAGES-1:0] r_syncChain;
  logic [CNT_W-1:0]       r_stableCount;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;

  logic w_norm;
  logic w_differs;
  logic w_atMax;
  logic w_toggle;

  // Synchroniser chain. Reset loads the inversion bit so that the
  // normalised level reads "released" straight out of reset and no
  // spurious qualification starts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_syncChain <= {SYNC_STAGES{INV}};
    end else begin
      r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Normalised level compared against the current debounced state. The
  // level toggles only once the mismatch has been seen with the counter
  // already at its terminal value, so the counter never wraps.
  always_comb begin
    w_norm    = r_syncChain[SYNC_STAGES-1] ^ INV;
    w_differs = (w_norm != r_level);
    w_atMax   = (r_stableCount == CNT_W'(CNT_MAX));
    w_toggle  = w_differs && w_atMax;
  end

  // Stability counter: any agreement (a bounce back) restarts the count,
  // and a completed qualification also clears it on the toggle edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stableCount <= '0;
    end else if (!w_differs || w_atMax) begin
      r_stableCount <= '0;
    end else begin
      r_stableCount <= r_stableCount + CNT_W'(1);
    end
  end

  // Debounced level and its edge pulses, all updated on the same edge so
  // the pulses line up exactly with the level change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_toggle && !r_level;
      r_release <= w_toggle && r_level;
      if (w_toggle) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  generate
    if (LONG_EN != 0) begin : g_long
      logic [HOLD_W-1:0] r_holdCount;
      logic              r_long;

      // Hold counter: zero while released (and on the release edge itself),
      // counts while pressed and parks at the threshold so the long-press
      // pulse cannot repeat within one press.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_holdCount <= '0;
        end else if (!r_level || w_toggle) begin
          r_holdCount <= '0;
        end else if (r_holdCount != HOLD_W'(HOLD_MAX)) begin
          r_holdCount <= r_holdCount + HOLD_W'(1);
        end
      end

      // Long-press pulse fires on the edge the counter reaches the
      // threshold. It is suppressed if the button is releasing on that
      // same edge, so a release and a long press never coincide.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_long <= 1'b0;
        end else begin
          r_long <= r_level && !w_toggle && (r_holdCount == HOLD_W'(HOLD_MAX - 1));
        end
      end

      assign o_long = r_long;
    end else begin : g_noLong
      assign o_long = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/btn_debounce_array.sv
// ---------------------------------------------------------------------------
// btn_debounce_array
// Array of N_CH independent button debouncers with press, release and
// long-press pulse outputs. Each channel is a separate debounce_ch instance;
// nothing is shared between channels.
// Ports:
//   CLK        system clock, all state on the rising edge
//   RST        synchronous active-high reset
//   BTN_I      raw asynchronous button levels
//   BTN_O      debounced, normalised levels (1 = pressed)
//   PRESS_O    one-cycle pulse per channel on BTN_O 0->1
//   RELEASE_O  one-cycle pulse per channel on BTN_O 1->0
//   LONG_O     one-cycle pulse per channel after HOLD_MAX cycles held
// ---------------------------------------------------------------------------
module btn_debounce_array
  import debounce_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              CNT_W       = DEF_CNT_W,
  parameter int              CNT_MAX     = DEF_CNT_MAX,
  parameter int              SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [N_CH-1:0] INV_MASK    = {N_CH{1'b0}},
  parameter int              HOLD_W      = DEF_HOLD_W,
  parameter int              HOLD_MAX    = DEF_HOLD_MAX,
  parameter int              LONG_EN     = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN_I,
  output logic [N_CH-1:0] BTN_O,
  output logic [N_CH-1:0] PRESS_O,
  output logic [N_CH-1:0] RELEASE_O,
  output logic [N_CH-1:0] LONG_O
);

  // Parameter sanity checks, evaluated at elaboration
  generate
    if (N_CH < 1) begin : g_errNch
      $error("btn_debounce_array: N_CH must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 62) begin : g_errCntW
      $error("btn_debounce_array: CNT_W out of range");
    end
    if (!fitsWidth(longint'(CNT_MAX), CNT_W)) begin : g_errCntMax
      $error("btn_debounce_array: CNT_MAX must satisfy 1 <= CNT_MAX <= 2^CNT_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_errSync
      $error("btn_debounce_array: SYNC_STAGES must be at least 2");
    end
    if (LONG_EN != 0 && (HOLD_W < 1 || HOLD_W > 62)) begin : g_errHoldW
      $error("btn_debounce_array: HOLD_W out of range");
    end
    if (LONG_EN != 0 && !fitsWidth(longint'(HOLD_MAX), HOLD_W)) begin : g_errHoldMax
      $error("btn_debounce_array: HOLD_MAX must satisfy 1 <= HOLD_MAX <= 2^HOLD_W-1");
    end
  endgenerate

  // One debouncer per channel; only the inversion bit differs per instance
  generate
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      debounce_ch #(
        .CNT_W       (CNT_W),
        .CNT_MAX     (CNT_MAX),
        .SYNC_STAGES (SYNC_STAGES),
        .INV         (INV_MASK[ch]),
        .HOLD_W      (HOLD_W),
        .HOLD_MAX    (HOLD_MAX),
        .LONG_EN     (LONG_EN)
      ) u_ch (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_btn     (BTN_I[ch]),
        .o_level   (BTN_O[ch]),
        .o_press   (PRESS_O[ch]),
        .o_release (RELEASE_O[ch]),
        .o_long    (LONG_O[ch])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_array.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_array
// Directed bench for btn_debounce_array with N_CH=2, CNT_MAX=15,
// SYNC_STAGES=2, HOLD_MAX=40. dutA has no inversion, dutB inverts channel 1.
// Inputs are driven 1 ns after a rising edge; outputs are sampled at that
// same point, i.e. reflecting the edge just taken. An input driven after
// edge e is first sampled on edge e+1, so the debounced level changes on
// edge e+1+2+15 = e+18.
// ---------------------------------------------------------------------------
module tb_btn_debounce_array;

  logic       CLK;
  logic       RST;
  logic [1:0] btnA;
  logic [1:0] btnB;
  logic [1:0] levelA, pressA, releaseA, longA;
  logic [1:0] levelB, pressB, releaseB, longB;

  int checks;
  int errors;

  btn_debounce_array #(
    .N_CH(2), .CNT_W(4), .CNT_MAX(15), .SYNC_STAGES(2),
    .INV_MASK(2'b00), .HOLD_W(6), .HOLD_MAX(40), .LONG_EN(1)
  ) dutA (
    .CLK(CLK), .RST(RST), .BTN_I(btnA),
    .BTN_O(levelA), .PRESS_O(pressA), .RELEASE_O(releaseA), .LONG_O(longA)
  );

  btn_debounce_array #(
    .N_CH(2), .CNT_W(4), .CNT_MAX(15), .SYNC_STAGES(2),
    .INV_MASK(2'b10), .HOLD_W(6), .HOLD_MAX(40), .LONG_EN(1)
  ) dutB (
    .CLK(CLK), .RST(RST), .BTN_I(btnB),
    .BTN_O(levelB), .PRESS_O(pressB), .RELEASE_O(releaseB), .LONG_O(longB)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
    btnA = a;
    btnB = b;
  endtask

  // Three-cycle reset with the given button levels held throughout
  task automatic doReset(input logic [1:0] a, input logic [1:0] b);
    RST = 1'b1;
    applyStimulus(a, b);
    repeat (3) tick();
    RST = 1'b0;
  endtask

  // Reset state, then both held channels of dutA rise 18 edges after deassert
  task automatic test_reset();
    doReset(2'b11, 2'b10);
    checks++;
    if ({levelA, pressA, releaseA, longA} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outA: got %b expected 00000000", {levelA, pressA, releaseA, longA});
    end
    checks++;
    if ({levelB, pressB, releaseB, longB} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outB: got %b expected 00000000", {levelB, pressB, releaseB, longB});
    end
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if ({levelA, pressA} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_qualify edge %0d: got %b expected 0000", i, {levelA, pressA});
      end
    end
    tick();
    checks++;
    if ({levelA, pressA} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_rise: got %b expected 1111", {levelA, pressA});
    end
    checks++;
    if ({levelB, pressB} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_inv_idle: got %b expected 0000", {levelB, pressB});
    end
    tick();
    checks++;
    if ({levelA, pressA} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_press_one_cycle: got %b expected 1100", {levelA, pressA});
    end
  endtask

  // Continues from test_reset: rise was one edge ago; long press at rise+40
  task automatic test_long_press();
    for (int i = 2; i <= 39; i++) begin
      tick();
      checks++;
      if (longA !== 2'b00) begin
        errors++;
        $display("[TB] FAIL long_early rise+%0d: got %b expected 00", i, longA);
      end
    end
    tick();
    checks++;
    if (longA !== 2'b11) begin
      errors++;
      $display("[TB] FAIL long_pulse: got %b expected 11", longA);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({levelA, longA} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL long_once: got %b expected 1100", {levelA, longA});
      end
    end
    // Release channel 0 only
    applyStimulus(2'b10, 2'b10);
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if ({levelA, releaseA} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL release_wait edge %0d: got %b expected 1100", i, {levelA, releaseA});
      end
    end
    tick();
    checks++;
    if ({levelA, releaseA, longA} !== 6'b100100) begin
      errors++;
      $display("[TB] FAIL release_fall: got %b expected 100100", {levelA, releaseA, longA});
    end
    tick();
    checks++;
    if (releaseA !== 2'b00) begin
      errors++;
      $display("[TB] FAIL release_one_cycle: got %b expected 00", releaseA);
    end
  endtask

  // Bounce: 10 high, 2 low, then held high; only the final run qualifies
  task automatic test_bounce();
    doReset(2'b00, 2'b10);
    applyStimulus(2'b01, 2'b10);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (levelA !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bounce_first_run: got %b expected 00", levelA);
      end
    end
    applyStimulus(2'b00, 2'b10);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (levelA !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bounce_gap: got %b expected 00", levelA);
      end
    end
    applyStimulus(2'b01, 2'b10);
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if ({levelA, pressA} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bounce_requalify edge %0d: got %b expected 0000", i, {levelA, pressA});
      end
    end
    tick();
    checks++;
    if ({levelA, pressA} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL bounce_rise: got %b expected 0101", {levelA, pressA});
    end
  endtask

  // dutB channel 1 is active-low: held 1 through reset means released
  task automatic test_inverted();
    doReset(2'b00, 2'b10);
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if ({levelB, pressB} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL inv_idle: got %b expected 0000", {levelB, pressB});
      end
    end
    applyStimulus(2'b00, 2'b00);
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (levelB !== 2'b00) begin
        errors++;
        $display("[TB] FAIL inv_qualify edge %0d: got %b expected 00", i, levelB);
      end
    end
    tick();
    checks++;
    if ({levelB, pressB} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL inv_press: got %b expected 1010", {levelB, pressB});
    end
    tick();
    checks++;
    if (pressB !== 2'b00) begin
      errors++;
      $display("[TB] FAIL inv_press_one_cycle: got %b expected 00", pressB);
    end
  endtask

  // One-cycle reset with the counter at 10 discards progress
  task automatic test_reset_mid();
    doReset(2'b00, 2'b10);
    applyStimulus(2'b01, 2'b10);
    repeat (12) tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({levelA, pressA, releaseA, longA} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected 00000000", {levelA, pressA, releaseA, longA});
    end
    RST = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if ({levelA, pressA, releaseA} !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL midreset_restart edge %0d: got %b expected 000000", i, {levelA, pressA, releaseA});
      end
    end
    tick();
    checks++;
    if ({levelA, pressA} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL midreset_rise: got %b expected 0101", {levelA, pressA});
    end
  endtask

  // 15-cycle pulse is rejected, 16-cycle pulse is accepted then falls back
  task automatic test_min_pulse();
    doReset(2'b00, 2'b10);
    applyStimulus(2'b01, 2'b10);
    repeat (15) tick();
    applyStimulus(2'b00, 2'b10);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({levelA, pressA} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL pulse15_rejected: got %b expected 0000", {levelA, pressA});
      end
    end
    applyStimulus(2'b01, 2'b10);
    repeat (16) tick();
    applyStimulus(2'b00, 2'b10);
    repeat (2) tick();
    checks++;
    if ({levelA, pressA} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL pulse16_accepted: got %b expected 0101", {levelA, pressA});
    end
    repeat (15) tick();
    checks++;
    if (levelA !== 2'b01) begin
      errors++;
      $display("[TB] FAIL pulse16_hold: got %b expected 01", levelA);
    end
    tick();
    checks++;
    if ({levelA, releaseA} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL pulse16_fall: got %b expected 0001", {levelA, releaseA});
    end
  endtask

  // Both channels together; short press gives no long pulse
  task automatic test_back_to_back();
    doReset(2'b00, 2'b10);
    applyStimulus(2'b11, 2'b10);
    repeat (17) tick();
    checks++;
    if (levelA !== 2'b00) begin
      errors++;
      $display("[TB] FAIL parallel_wait: got %b expected 00", levelA);
    end
    tick();
    checks++;
    if ({levelA, pressA} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL parallel_rise: got %b expected 1111", {levelA, pressA});
    end
    repeat (5) tick();
    applyStimulus(2'b00, 2'b10);
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if ({levelA, longA} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL parallel_held edge %0d: got %b expected 1100", i, {levelA, longA});
      end
    end
    tick();
    checks++;
    if ({levelA, releaseA, longA} !== 6'b001100) begin
      errors++;
      $display("[TB] FAIL parallel_fall: got %b expected 001100", {levelA, releaseA, longA});
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (longA !== 2'b00) begin
        errors++;
        $display("[TB] FAIL short_no_long: got %b expected 00", longA);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    btnA   = 2'b00;
    btnB   = 2'b10;
    test_reset();
    test_long_press();
    test_bounce();
    test_inverted();
    test_reset_mid();
    test_min_pulse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
